// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and sizing helpers for the memory port arbiter.
//   - arb_state_t : arbiter FSM states
//   - owner_t     : which requester owns the current memory access
//   - starve_cnt_width() / STARVE_CNT_W : width of the fetch starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DATA
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int MAX_STARVE_DEFAULT = 4;

  // The counter has to hold every value 0..max_starve inclusive.
  function automatic int starve_cnt_width(input int max_starve);
    return $clog2(max_starve + 1);
  endfunction

  localparam int STARVE_CNT_W = $clog2(MAX_STARVE_DEFAULT + 1);

endpackage

// File: rtl/mem_arb_perf_counters.sv
// mem_arb_perf_counters
//   Free-running 32-bit performance counters for the memory port arbiter.
//   Both counters wrap at 2^32.
// Ports
//   clk          in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   stall_if     in   fetch is currently stalled
//   dm_accept    in   a data access is being accepted at this edge
//   perf_if_wait out  cycles spent with stall_if high
//   perf_dm_cnt  out  number of data accesses accepted
module mem_arb_perf_counters (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_if,
  input  logic        dm_accept,
  output logic [31:0] perf_if_wait,
  output logic [31:0] perf_dm_cnt
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_if_wait <= 32'd0;
      perf_dm_cnt  <= 32'd0;
    end else begin
      if (stall_if) begin
        perf_if_wait <= perf_if_wait + 32'd1;
      end
      if (dm_accept) begin
        perf_dm_cnt <= perf_dm_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and the
//   load/store stage (DM). Data accesses win ties, except when fetch has been
//   passed over MAX_STARVE times while waiting, in which case fetch wins.
//   Build option: define MEM_ARB_PERF_EN to add the perf_if_wait/perf_dm_cnt
//   counter ports (instantiates mem_arb_perf_counters).
// Ports
//   clk, resetn                     clock, async active-low reset
//   if_req/if_addr                  fetch request (held until if_valid)
//   if_gnt/if_valid/if_rdata        fetch accept pulse, done pulse, read data
//   dm_req/dm_we/dm_addr/dm_wdata   data request (held until dm_valid)
//   dm_gnt/dm_valid/dm_rdata        data accept pulse, done pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata  registered request to the memory macro
//   mem_ready/mem_rdata             memory completion and read data
//   stall_if/stall_mem              stall requests to the hazard unit
//   perf_if_wait/perf_dm_cnt        (MEM_ARB_PERF_EN only) perf counters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_dm_cnt
`endif
);

  localparam int CNT_W = starve_cnt_width(MAX_STARVE);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;

  logic   if_elig;
  logic   dm_elig;
  logic   fetch_wins;
  logic   accept_if;
  logic   accept_dm;
  logic   access_done;
  owner_t winner;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  // A requester whose valid pulse is showing is still holding req from the
  // access that just finished, so it must not be granted again this cycle.
  assign if_elig    = if_req & ~if_valid;
  assign dm_elig    = dm_req & ~dm_valid;
  assign fetch_wins = if_elig & (~dm_elig | (starve_cnt == STARVE_MAX));
  assign winner     = fetch_wins ? OWN_IF : OWN_DM;
  assign accept_if  = (state == ARB_IDLE) & fetch_wins;
  assign accept_dm  = (state == ARB_IDLE) & dm_elig & ~fetch_wins;

  // The macro first sees mem_req during the grant cycle, so a ready in that
  // cycle belongs to no access of ours; completion is only taken afterwards.
  assign access_done = (state != ARB_IDLE) & ~(if_gnt | dm_gnt) & mem_ready;

  // Arbiter FSM with registered memory-side request, pulses and read data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      if_gnt     <= 1'b0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_valid   <= 1'b0;
      dm_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt   <= 1'b0;
      dm_gnt   <= 1'b0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (accept_if || accept_dm) begin
            mem_req <= 1'b1;
            if (winner == OWN_IF) begin
              state      <= ARB_FETCH;
              if_gnt     <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              starve_cnt <= '0;
            end else begin
              state     <= ARB_DATA;
              dm_gnt    <= 1'b1;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (if_req && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end
        ARB_FETCH: begin
          if (access_done) begin
            state    <= ARB_IDLE;
            mem_req  <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        ARB_DATA: begin
          if (access_done) begin
            state    <= ARB_IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state   <= ARB_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_counters u_perf (
    .clk          (clk),
    .resetn       (resetn),
    .stall_if     (stall_if),
    .dm_accept    (accept_dm),
    .perf_if_wait (perf_if_wait),
    .perf_dm_cnt  (perf_dm_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: vector tables for the basic
//   fetch and contention cases, hand-written sequences for starvation, long
//   store and mid-access reset, then random traffic against a reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_STARVE = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [ADDR_W-1:0] dm_addr = '0;
  logic [DATA_W-1:0] dm_wdata = '0;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              stall_if;
  logic              stall_mem;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_if_wait;
  logic [31:0]       perf_dm_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_dm_cnt  (perf_dm_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  string phase = "init";

  // Reference model: one transaction in flight at most, tracked by owner and
  // age; outputs are what the arbiter should show in the coming cycle.
  bit          m_busy;
  bit          m_fetch;
  int          m_age;
  int          m_starve;
  bit          e_if_gnt, e_if_valid, e_dm_gnt, e_dm_valid, e_mem_req, e_mem_we;
  logic [31:0] e_if_rdata, e_dm_rdata, e_mem_addr, e_mem_wdata;
  logic [31:0] e_perf_if_wait, e_perf_dm_cnt;

  task automatic modelReset();
    m_busy = 0; m_fetch = 0; m_age = 0; m_starve = 0;
    e_if_gnt = 0; e_if_valid = 0; e_dm_gnt = 0; e_dm_valid = 0;
    e_mem_req = 0; e_mem_we = 0;
    e_if_rdata = '0; e_dm_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
    e_perf_if_wait = '0; e_perf_dm_cnt = '0;
  endtask

  task automatic modelStep();
    bit if_elig, dm_elig, take_if, take_dm;
    if (!resetn) return;
    if_elig = if_req && !e_if_valid;
    dm_elig = dm_req && !e_dm_valid;
    if (if_elig) e_perf_if_wait = e_perf_if_wait + 32'd1;
    e_if_gnt = 0; e_dm_gnt = 0; e_if_valid = 0; e_dm_valid = 0;
    if (!m_busy) begin
      take_if = if_elig && (!dm_elig || m_starve == MAX_STARVE);
      take_dm = dm_elig && !take_if;
      if (take_if) begin
        m_busy = 1; m_fetch = 1; m_age = 0; m_starve = 0;
        e_if_gnt = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr;
      end else if (take_dm) begin
        m_busy = 1; m_fetch = 0; m_age = 0;
        e_dm_gnt = 1; e_mem_req = 1; e_mem_we = dm_we;
        e_mem_addr = dm_addr; e_mem_wdata = dm_wdata;
        if (if_req && m_starve < MAX_STARVE) m_starve++;
        e_perf_dm_cnt = e_perf_dm_cnt + 32'd1;
      end
    end else if (m_age > 0 && mem_ready) begin
      m_busy = 0; e_mem_req = 0;
      if (m_fetch) begin
        e_if_valid = 1; e_if_rdata = mem_rdata;
      end else begin
        e_dm_valid = 1;
        if (!e_mem_we) e_dm_rdata = mem_rdata;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s/%s: got 0x%08h, expected 0x%08h at %0t", phase, name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
    checkVal("if_valid",  32'(if_valid),  32'(e_if_valid));
    checkVal("if_rdata",  if_rdata,       e_if_rdata);
    checkVal("dm_gnt",    32'(dm_gnt),    32'(e_dm_gnt));
    checkVal("dm_valid",  32'(dm_valid),  32'(e_dm_valid));
    checkVal("dm_rdata",  dm_rdata,       e_dm_rdata);
    checkVal("mem_req",   32'(mem_req),   32'(e_mem_req));
    checkVal("mem_we",    32'(mem_we),    32'(e_mem_we));
    checkVal("mem_addr",  mem_addr,       e_mem_addr);
    checkVal("mem_wdata", mem_wdata,      e_mem_wdata);
    checkVal("stall_if",  32'(stall_if),  32'(if_req && !e_if_valid));
    checkVal("stall_mem", 32'(stall_mem), 32'(dm_req && !e_dm_valid));
`ifdef MEM_ARB_PERF_EN
    checkVal("perf_if_wait", perf_if_wait, e_perf_if_wait);
    checkVal("perf_dm_cnt",  perf_dm_cnt,  e_perf_dm_cnt);
`endif
  endtask

  task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                               input logic [31:0] da, input logic [31:0] dwd,
                               input bit rdy, input logic [31:0] rd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
    mem_ready = rdy; mem_rdata = rd;
  endtask

  task automatic waitSample();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic cycle();
    waitSample();
    advance();
  endtask

  task automatic doReset();
    resetn = 0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    resetn = 1;
  endtask

  typedef struct {
    bit          if_req;
    logic [31:0] if_addr;
    bit          dm_req;
    bit          dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    bit          mem_ready;
    logic [31:0] mem_rdata;
    bit          x_if_gnt, x_if_valid, x_dm_gnt, x_dm_valid, x_mem_req, x_stall_if, x_stall_mem;
  } vec_t;

  function automatic vec_t mk(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                              input logic [31:0] da, input logic [31:0] dwd, input bit rdy,
                              input logic [31:0] rd, input bit gi, input bit vi, input bit gd,
                              input bit vd, input bit mr, input bit si, input bit sm);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw; v.dm_addr = da;
    v.dm_wdata = dwd; v.mem_ready = rdy; v.mem_rdata = rd;
    v.x_if_gnt = gi; v.x_if_valid = vi; v.x_dm_gnt = gd; v.x_dm_valid = vd;
    v.x_mem_req = mr; v.x_stall_if = si; v.x_stall_mem = sm;
    return v;
  endfunction

  task automatic runVector(input vec_t v);
    applyStimulus(v.if_req, v.if_addr, v.dm_req, v.dm_we, v.dm_addr, v.dm_wdata, v.mem_ready, v.mem_rdata);
    waitSample();
    checkVal("tbl_if_gnt",    32'(if_gnt),    32'(v.x_if_gnt));
    checkVal("tbl_if_valid",  32'(if_valid),  32'(v.x_if_valid));
    checkVal("tbl_dm_gnt",    32'(dm_gnt),    32'(v.x_dm_gnt));
    checkVal("tbl_dm_valid",  32'(dm_valid),  32'(v.x_dm_valid));
    checkVal("tbl_mem_req",   32'(mem_req),   32'(v.x_mem_req));
    checkVal("tbl_stall_if",  32'(stall_if),  32'(v.x_stall_if));
    checkVal("tbl_stall_mem", 32'(stall_mem), 32'(v.x_stall_mem));
    advance();
  endtask

  vec_t t_fetch[5];
  vec_t t_both[8];

  initial begin
    logic [31:0] saved_rdata;
    int          valid_seen;

    //                 ir  ia      dr dw da        dwd rdy rd            gi vi gd vd mr si sm
    t_fetch[0] = mk(1, 32'h100, 0, 0, 32'h0,    0,  1, 32'hA100_0000, 0, 0, 0, 0, 0, 1, 0);
    t_fetch[1] = mk(1, 32'h100, 0, 0, 32'h0,    0,  1, 32'hA100_0001, 1, 0, 0, 0, 1, 1, 0);
    t_fetch[2] = mk(1, 32'h100, 0, 0, 32'h0,    0,  1, 32'hA100_0002, 0, 0, 0, 0, 1, 1, 0);
    t_fetch[3] = mk(1, 32'h100, 0, 0, 32'h0,    0,  1, 32'hA100_0003, 0, 1, 0, 0, 0, 0, 0);
    t_fetch[4] = mk(0, 32'h100, 0, 0, 32'h0,    0,  1, 32'hA100_0004, 0, 0, 0, 0, 0, 0, 0);

    t_both[0]  = mk(1, 32'h100, 1, 0, 32'h2000, 0,  1, 32'hB000_0000, 0, 0, 0, 0, 0, 1, 1);
    t_both[1]  = mk(1, 32'h100, 1, 0, 32'h2000, 0,  1, 32'hB000_0001, 0, 0, 1, 0, 1, 1, 1);
    t_both[2]  = mk(1, 32'h100, 1, 0, 32'h2000, 0,  1, 32'hB000_0002, 0, 0, 0, 0, 1, 1, 1);
    t_both[3]  = mk(1, 32'h100, 1, 0, 32'h2000, 0,  1, 32'hB000_0003, 0, 0, 0, 1, 0, 1, 0);
    t_both[4]  = mk(1, 32'h100, 0, 0, 32'h2000, 0,  1, 32'hB000_0004, 1, 0, 0, 0, 1, 1, 0);
    t_both[5]  = mk(1, 32'h100, 0, 0, 32'h2000, 0,  1, 32'hB000_0005, 0, 0, 0, 0, 1, 1, 0);
    t_both[6]  = mk(1, 32'h100, 0, 0, 32'h2000, 0,  1, 32'hB000_0006, 0, 1, 0, 0, 0, 0, 0);
    t_both[7]  = mk(0, 32'h100, 0, 0, 32'h2000, 0,  1, 32'hB000_0007, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] start");
    modelReset();

    phase = "reset";
    doReset();

    phase = "fetch_only";
    foreach (t_fetch[i]) runVector(t_fetch[i]);
    checkVal("fetch_rdata", if_rdata, 32'hA100_0002);

    phase = "both_req";
    doReset();
    foreach (t_both[i]) runVector(t_both[i]);
    checkVal("load_rdata",  dm_rdata, 32'hB000_0002);
    checkVal("fetch_rdata", if_rdata, 32'hB000_0005);
`ifdef MEM_ARB_PERF_EN
    checkVal("perf_dm_total",   perf_dm_cnt,  32'd1);
    checkVal("perf_wait_total", perf_if_wait, 32'd6);
`endif

    // Four data wins while fetch is asking, then fetch is forced through.
    phase = "starve";
    doReset();
    for (int r = 0; r < MAX_STARVE; r++) begin
      applyStimulus(1, 32'h300, 1, 0, 32'h3000 + r, 0, 1, 32'hC000_0000 + r);
      cycle();
      applyStimulus(0, 32'h300, 1, 0, 32'h3000 + r, 0, 1, 32'hC000_0000 + r);
      waitSample();
      checkVal("starve_dm_gnt", 32'(dm_gnt), 32'd1);
      checkVal("starve_if_gnt", 32'(if_gnt), 32'd0);
      advance();
      cycle();
      applyStimulus(0, 32'h300, 0, 0, 32'h3000 + r, 0, 1, 32'hC000_0000 + r);
      cycle();
    end
    applyStimulus(1, 32'h300, 1, 0, 32'h3100, 0, 1, 32'hC100_0000);
    cycle();
    waitSample();
    checkVal("forced_if_gnt", 32'(if_gnt), 32'd1);
    checkVal("forced_dm_gnt", 32'(dm_gnt), 32'd0);
    advance();
    cycle();
    applyStimulus(0, 32'h300, 1, 0, 32'h3100, 0, 1, 32'hC100_0000);
    cycle();
    waitSample();
    checkVal("resume_dm_gnt", 32'(dm_gnt), 32'd1);
    advance();
    cycle();
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    cycle();

    // Store held for several cycles by a slow memory.
    phase = "slow_store";
    saved_rdata = dm_rdata;
    valid_seen  = 0;
    applyStimulus(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF, 0, 32'h5555_5555);
    for (int c = 0; c < 9; c++) begin
      mem_ready = (c == 6);
      if (c == 8) dm_req = 0;
      waitSample();
      if (dm_valid) valid_seen++;
      if (c >= 1 && c <= 6) begin
        checkVal("store_mem_req",   32'(mem_req), 32'd1);
        checkVal("store_mem_we",    32'(mem_we),  32'd1);
        checkVal("store_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
        checkVal("store_mem_addr",  mem_addr,     32'h40);
      end
      if (c == 7) checkVal("store_dm_valid", 32'(dm_valid), 32'd1);
      advance();
    end
    checkVal("store_valid_count", 32'(valid_seen), 32'd1);
    checkVal("store_dm_rdata",    dm_rdata,        saved_rdata);

    // Reset in the middle of a data access, then a clean fetch.
    phase = "reset_mid";
    applyStimulus(0, 0, 1, 0, 32'h80, 0, 0, 32'h7777_0000);
    cycle();
    cycle();
    #2;
    resetn = 0;
    modelReset();
    #1;
    checkVal("reset_mem_req", 32'(mem_req), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h7777_0001);
    cycle();
    resetn = 1;
    applyStimulus(1, 32'h500, 0, 0, 0, 0, 1, 32'h7777_0002);
    valid_seen = 0;
    for (int c = 0; c < 5; c++) begin
      waitSample();
      if (if_valid) valid_seen++;
      if (c == 3) if_req = 0;
      advance();
    end
    checkVal("post_reset_if_valid", 32'(valid_seen), 32'd1);
    checkVal("post_reset_if_rdata", if_rdata, 32'h7777_0002);

    // Random traffic, including requests withdrawn before acceptance.
    phase = "random";
    doReset();
    for (int c = 0; c < 1500; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom_range(0, 2) != 0, $urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
